// File: rtl/muldiv_unit_if.sv
// Handshake/bus bundle for the iterative multiply/divide unit.
// Pipeline side drives requests; unit side returns status and HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_rs;
  logic [WIDTH-1:0] i_rt;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_rs, i_rt,
    output i_hi_we, i_lo_we, i_wdata,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_rs, i_rt,
    input  i_hi_we, i_lo_we, i_wdata,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle,
// with architectural HI/LO and MTHI/MTLO write port.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_acc;
  logic               r_div;
  logic               r_na;
  logic               r_nb;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_sgn;
  logic               w_na;
  logic               w_nb;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic               w_last;
  logic               w_accept;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ok;
  logic [WIDTH-1:0]   w_acc_n;
  logic [WIDTH-1:0]   w_q_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;
  logic               w_unused;

  assign w_sgn    = ~bus.i_op[0];
  assign w_na     = w_sgn & bus.i_rs[WIDTH-1];
  assign w_nb     = w_sgn & bus.i_rt[WIDTH-1];
  assign w_rs_mag = w_na ? -bus.i_rs : bus.i_rs;
  assign w_rt_mag = w_nb ? -bus.i_rt : bus.i_rt;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == S_IDLE) && bus.i_start;

  // shift-add multiply step: add multiplicand, shift {acc,q} right
  assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : '0);

  // restoring divide step: shift in next dividend bit, trial subtract
  assign w_sh   = {r_acc, r_q[WIDTH-1]};
  assign w_diff = {1'b0, w_sh} - {2'b0, r_a};
  assign w_ok   = ~w_diff[WIDTH+1];

  // remainder always fits WIDTH bits, so diff bit WIDTH is zero when kept
  assign w_unused = &{1'b0, w_diff[WIDTH]};

  // select the per-cycle iteration result for the current op class
  always_comb begin
    w_acc_n = r_acc;
    w_q_n   = r_q;
    unique case (1'b1)
      r_div: begin
        w_acc_n = w_ok ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
        w_q_n   = {r_q[WIDTH-2:0], w_ok};
      end
      default: begin
        w_acc_n = w_sum[WIDTH:1];
        w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
      end
    endcase
  end

  // sign fix-up and HI/LO result formation
  always_comb begin
    w_prod   = {r_acc, r_q};
    w_prod_s = (r_na ^ r_nb) ? -w_prod : w_prod;
    w_quo    = (r_na ^ r_nb) ? -r_q : r_q;
    w_rem    = r_na ? -r_acc : r_acc;
    w_hi_res = w_prod_s[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod_s[WIDTH-1:0];
    unique case (1'b1)
      r_div: begin
        w_hi_res = w_rem;
        w_lo_res = r_dz ? '1 : w_quo;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  // next-state logic
  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_start) w_nstate = S_CALC;
      S_CALC:  if (w_last) w_nstate = S_FIX;
      S_FIX:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // operand scratch: load on accept, iterate in CALC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      r_div <= 1'b0;
      r_na  <= 1'b0;
      r_nb  <= 1'b0;
      r_dz  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_div <= bus.i_op[1];
      r_na  <= w_na;
      r_nb  <= w_nb;
      r_dz  <= (bus.i_rt == '0);
      if (bus.i_op[1]) begin
        r_a <= w_rt_mag;
        r_q <= w_rs_mag;
      end else begin
        r_a <= w_rs_mag;
        r_q <= w_rt_mag;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_n;
      r_q   <= w_q_n;
    end
  end

  // HI/LO: result on FIX, MTHI/MTLO only in IDLE without a start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_hi_res;
      r_lo <= w_lo_res;
    end else if (r_state == S_IDLE && !bus.i_start) begin
      if (bus.i_hi_we) r_hi <= bus.i_wdata;
      if (bus.i_lo_we) r_lo <= bus.i_wdata;
    end
  end

  // completion pulse, one cycle after FIX
  always_ff @(posedge i_clk) begin
    if (i_rst) r_done <= 1'b0;
    else       r_done <= (r_state == S_FIX);
  end

  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_done = r_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus
// MTHI/MTLO, busy-interlock and mid-op reset sequences.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always @(posedge clk) if (bus.o_done) done_cnt++;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // launch one op; returns edges from start to done and busy samples
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output int bcnt);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_rs    = a;
    bus.i_rt    = b;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_rs    = 32'hDEAD_BEEF;
    bus.i_rt    = 32'h1234_5678;
    bus.i_op    = ~op;
    lat  = 0;
    bcnt = 0;
    while (!bus.o_done && lat < 100) begin
      if (bus.o_busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    vt[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[4]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vt[5]  = '{2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
    vt[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[7]  = '{2'b01, 32'd6,        32'd7,        32'h00000000, 32'h0000002A};
    vt[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[9]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[10] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vt[11] = '{2'b11, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999};
    vt[12] = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};

    bus.i_start = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_rs    = '0;
    bus.i_rt    = '0;
    bus.i_hi_we = 1'b0;
    bus.i_lo_we = 1'b0;
    bus.i_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);

    // vector table, back-to-back (each start lands in the done cycle)
    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].rs, vt[i].rt, lat, bcnt);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd33);
      chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'd33);
      chk($sformatf("v%0d_bz", i), 64'(bus.o_busy), 64'd0);
      chk($sformatf("v%0d_hi", i), 64'(bus.o_hi), 64'(vt[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(bus.o_lo), 64'(vt[i].lo));
    end
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(bus.o_done), 64'd0);

    // MTHI then MTLO, each visible next cycle
    @(negedge clk);
    bus.i_hi_we = 1'b1;
    bus.i_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    chk("mthi", 64'(bus.o_hi), 64'h12345678);
    bus.i_hi_we = 1'b0;
    bus.i_lo_we = 1'b1;
    bus.i_wdata = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    chk("mtlo", {bus.o_hi, bus.o_lo}, 64'h12345678_9ABCDEF0);
    bus.i_hi_we = 1'b1;
    bus.i_wdata = 32'h0000_55AA;
    @(posedge clk);
    #1;
    chk("mt_both", {bus.o_hi, bus.o_lo}, 64'h000055AA_000055AA);
    bus.i_hi_we = 1'b0;
    bus.i_lo_we = 1'b0;

    // start and MTLO together: start wins, LO unchanged next cycle
    done_cnt = 0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = 2'b01;
    bus.i_rs    = 32'd6;
    bus.i_rt    = 32'd7;
    bus.i_lo_we = 1'b1;
    bus.i_wdata = 32'hFFFF0000;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    chk("start_wins", 64'(bus.o_lo), 64'h000055AA);
    // MTLO while busy is dropped; HI/LO hold old value mid-op
    bus.i_wdata = 32'h1;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_hilo", {bus.o_hi, bus.o_lo}, 64'h000055AA_000055AA);
    bus.i_lo_we = 1'b0;
    // second start while busy is ignored
    bus.i_start = 1'b1;
    bus.i_op    = 2'b01;
    bus.i_rs    = 32'd2;
    bus.i_rt    = 32'd2;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    lat = 0;
    while (!bus.o_done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_done_seen", 64'(bus.o_done), 64'd1);
    chk("busy_res", {bus.o_hi, bus.o_lo}, 64'h00000000_0000002A);
    repeat (40) @(posedge clk);
    #1;
    chk("single_done", 64'(done_cnt), 64'd1);
    chk("busy_idle", 64'(bus.o_busy), 64'd0);

    // reset in the middle of a DIV aborts it
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = 2'b10;
    bus.i_rs    = 32'd1000;
    bus.i_rt    = 32'd3;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.o_busy), 64'd1);
    done_cnt = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 64'(bus.o_busy), 64'd0);
    chk("abort_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_nodone", 64'(done_cnt), 64'd0);
    run_op(2'b01, 32'd6, 32'd7, lat, bcnt);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_res", {bus.o_hi, bus.o_lo}, 64'h00000000_0000002A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
